// File: rtl/pw_sequence_checker_if.sv
// Pushbutton panel bus: raw button levels in, lock status out.
interface pw_sequence_checker_if;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       unlock;
  logic       fail;
  logic       locked_out;
  logic [2:0] entry_count;

  modport master (
    output a, b, c, d,
    input  unlock, fail, locked_out, entry_count
  );

  modport slave (
    input  a, b, c, d,
    output unlock, fail, locked_out, entry_count
  );
endinterface

// File: rtl/pw_sequence_checker.sv
// Keypad code checker: synchronises four buttons, turns presses into key events, compares a
// CODE_LEN-key entry against CODE and drives unlock / fail / lockout status.
module pw_sequence_checker #(
  parameter int unsigned           CODE_LEN    = 4,
  parameter logic [2*CODE_LEN-1:0] CODE        = 8'b11_10_01_00,
  parameter int unsigned           TIMEOUT_CYC = 50_000_000,
  parameter int unsigned           OPEN_CYC    = 100_000_000,
  parameter int unsigned           LOCKOUT_CYC = 500_000_000,
  parameter int unsigned           MAX_FAILS   = 3
) (
  input logic                   clkin,
  input logic                   reset,
  pw_sequence_checker_if.slave  pw_if
);

  localparam int unsigned MaxAB  = (TIMEOUT_CYC > OPEN_CYC) ? TIMEOUT_CYC : OPEN_CYC;
  localparam int unsigned MaxCyc = (MaxAB > LOCKOUT_CYC) ? MaxAB : LOCKOUT_CYC;
  localparam int unsigned TimerW = $clog2(MaxCyc + 1);
  localparam int unsigned FailW  = (MAX_FAILS > 1) ? $clog2(MAX_FAILS + 1) : 1;

  typedef enum logic [1:0] {StIdle, StEntry, StOpen, StLockout} state_e;

  state_e              r_state;
  logic [3:0]          r_s1;
  logic [3:0]          r_s2;
  logic [3:0]          r_p;
  logic [2:0]          r_count;
  logic                r_mismatch;
  logic [TimerW-1:0]   r_timer;
  logic [FailW-1:0]    r_fails;
  logic                r_unlock;
  logic                r_fail;
  logic                r_locked;

  logic [3:0]          w_btn;
  logic [3:0]          w_rise;
  logic [3:0]          w_other;
  logic [2:0]          w_rise_cnt;
  logic                w_event;
  logic                w_invalid;
  logic [1:0]          w_key_id;
  logic [1:0]          w_exp_id;
  logic [2:0]          w_count_inc;
  logic                w_mis_acc;
  logic                w_complete;
  logic                w_timeout;
  logic                w_accepting;
  logic                w_fail_now;
  logic                w_last_fail;

  assign w_btn = {pw_if.d, pw_if.c, pw_if.b, pw_if.a};

  always_comb begin
    w_rise     = r_s2 & ~r_p;
    w_event    = |w_rise;
    w_rise_cnt = 3'(w_rise[0]) + 3'(w_rise[1]) + 3'(w_rise[2]) + 3'(w_rise[3]);
    // Any other button already down turns the press into a chord, which never matches.
    w_other    = r_s2 & ~w_rise;
    w_invalid  = (w_rise_cnt > 3'd1) | (|w_other);

    w_key_id = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_rise[i]) w_key_id = 2'(i);
    end

    w_exp_id = CODE[1:0];
    for (int unsigned k = 0; k < CODE_LEN; k++) begin
      if (r_count == 3'(k)) w_exp_id = CODE[2*k +: 2];
    end

    w_count_inc = r_count + 3'd1;
    w_mis_acc   = r_mismatch | w_invalid | (w_key_id != w_exp_id);
    w_complete  = (w_count_inc == 3'(CODE_LEN));
    w_timeout   = (r_timer == TimerW'(TIMEOUT_CYC - 1));
    w_accepting = (r_state == StIdle) || (r_state == StEntry);
    w_fail_now  = w_accepting &&
                  ((w_event && w_complete && w_mis_acc) ||
                   (r_state == StEntry && !w_event && w_timeout));
    w_last_fail = (r_fails == FailW'(MAX_FAILS - 1));
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state    <= StIdle;
      r_s1       <= '0;
      r_s2       <= '0;
      r_p        <= '0;
      r_count    <= '0;
      r_mismatch <= 1'b0;
      r_timer    <= '0;
      r_fails    <= '0;
      r_unlock   <= 1'b0;
      r_fail     <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_s1   <= w_btn;
      r_s2   <= r_s1;
      r_p    <= r_s2;
      r_fail <= 1'b0;

      unique case (r_state)
        StIdle, StEntry: begin
          if (w_fail_now) begin
            r_fail     <= 1'b1;
            r_count    <= '0;
            r_mismatch <= 1'b0;
            r_timer    <= '0;
            if (w_last_fail) begin
              r_state <= StLockout;
              r_fails <= '0;
            end else begin
              r_state <= StIdle;
              r_fails <= r_fails + FailW'(1);
            end
          end else if (w_event && w_complete) begin
            r_state    <= StOpen;
            r_unlock   <= 1'b1;
            r_fails    <= '0;
            r_count    <= '0;
            r_mismatch <= 1'b0;
            r_timer    <= '0;
          end else if (w_event) begin
            r_state    <= StEntry;
            r_count    <= w_count_inc;
            r_mismatch <= w_mis_acc;
            r_timer    <= '0;
          end else if (r_state == StEntry) begin
            r_timer <= r_timer + TimerW'(1);
          end
        end

        StOpen: begin
          if (r_timer == TimerW'(OPEN_CYC - 1)) begin
            r_state  <= StIdle;
            r_unlock <= 1'b0;
            r_timer  <= '0;
          end else begin
            r_timer <= r_timer + TimerW'(1);
          end
        end

        // One settling cycle after the final fail pulse keeps fail and locked_out disjoint.
        StLockout: begin
          if (r_timer == TimerW'(LOCKOUT_CYC)) begin
            r_state  <= StIdle;
            r_locked <= 1'b0;
            r_timer  <= '0;
          end else begin
            r_locked <= 1'b1;
            r_timer  <= r_timer + TimerW'(1);
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign pw_if.unlock      = r_unlock;
  assign pw_if.fail        = r_fail;
  assign pw_if.locked_out  = r_locked;
  assign pw_if.entry_count = r_count;

endmodule

// File: tb/tb_pw_sequence_checker.sv
// Bench for pw_sequence_checker: directed scenarios plus random presses against a timeline model.
module tb_pw_sequence_checker;

  localparam int Timeout  = 20;
  localparam int OpenCyc  = 10;
  localparam int LockCyc  = 30;
  localparam int MaxFails = 3;
  localparam int CodeLen  = 4;
  localparam logic [7:0] TbCode = 8'b11_10_01_00;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  int         passed;
  int         total;

  pw_sequence_checker_if pw ();

  assign pw.a = btn[0];
  assign pw.b = btn[1];
  assign pw.c = btn[2];
  assign pw.d = btn[3];

  pw_sequence_checker #(
    .CODE_LEN   (4),
    .CODE       (8'b11_10_01_00),
    .TIMEOUT_CYC(Timeout),
    .OPEN_CYC   (OpenCyc),
    .LOCKOUT_CYC(LockCyc),
    .MAX_FAILS  (MaxFails)
  ) dut (
    .clkin (clk),
    .reset (rst),
    .pw_if (pw)
  );

  always #5 clk = ~clk;

  // Model: raw samples delayed two edges, keys in a queue, OPEN/LOCKOUT as absolute time windows.
  int         cyc = 0;
  logic [3:0] h1, h2, h3;
  int         keys[$];
  int         last_key, fails, busy_until, un_from, un_to, lk_from, lk_to;
  logic       m_fail;

  function automatic int code_key(input int i);
    logic [7:0] c;
    c = TbCode >> (2 * i);
    return int'(c[1:0]);
  endfunction

  task automatic model_fail(input int n);
    m_fail = 1'b1;
    fails++;
    if (fails == MaxFails) begin
      fails      = 0;
      lk_from    = n + 1;
      lk_to      = n + 1 + LockCyc;
      busy_until = n + 1 + LockCyc;
    end
  endtask

  always @(posedge clk) begin
    logic [3:0] rise, lvl;
    int         id;
    bit         ok;
    cyc++;
    if (rst) begin
      h1 = '0; h2 = '0; h3 = '0;
      keys.delete();
      fails = 0; last_key = 0; busy_until = -1;
      un_from = 0; un_to = 0; lk_from = 0; lk_to = 0;
      m_fail = 1'b0;
    end else begin
      lvl  = h2;
      rise = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = btn;
      m_fail = 1'b0;
      if (cyc > busy_until) begin
        if (rise != 4'd0) begin
          id = -1;
          if ($countones(rise) == 1 && (lvl & ~rise) == 4'd0)
            for (int i = 0; i < 4; i++) if (rise[i]) id = i;
          keys.push_back(id);
          last_key = cyc;
          if (keys.size() == CodeLen) begin
            ok = 1'b1;
            for (int i = 0; i < CodeLen; i++) if (keys[i] != code_key(i)) ok = 1'b0;
            keys.delete();
            if (ok) begin
              fails = 0; un_from = cyc; un_to = cyc + OpenCyc; busy_until = cyc + OpenCyc;
            end else begin
              model_fail(cyc);
            end
          end
        end else if (keys.size() > 0 && cyc - last_key == Timeout) begin
          keys.delete();
          model_fail(cyc);
        end
      end
    end
  end

  // Observation counters, cleared by each scenario.
  int   mon_diff, n_fail, n_unlock, n_lock, n_overlap, first_unlock_cyc, last_fail_cyc;
  int   diff_cyc;
  logic [5:0] diff_dut, diff_exp;

  always @(negedge clk) begin
    logic [5:0] d, e;
    d = {pw.unlock, pw.fail, pw.locked_out, pw.entry_count};
    e = {(cyc >= un_from && cyc < un_to), m_fail, (cyc >= lk_from && cyc < lk_to),
         3'(keys.size())};
    if (d !== e) begin
      mon_diff++;
      if (mon_diff == 1) begin diff_cyc = cyc; diff_dut = d; diff_exp = e; end
    end
    if (pw.fail === 1'b1) begin n_fail++; last_fail_cyc = cyc; end
    if (pw.unlock === 1'b1) begin
      n_unlock++;
      if (first_unlock_cyc < 0) first_unlock_cyc = cyc;
    end
    if (pw.locked_out === 1'b1) n_lock++;
    if (int'(pw.fail) + int'(pw.unlock) + int'(pw.locked_out) > 1) n_overlap++;
  end

  task automatic clear_mon();
    mon_diff = 0; n_fail = 0; n_unlock = 0; n_lock = 0; n_overlap = 0;
    first_unlock_cyc = -1; last_fail_cyc = -1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    btn = 4'd0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic press(input logic [3:0] m, input int hold, input int gap);
    btn = m;
    step(hold);
    btn = 4'd0;
    step(gap);
  endtask

  task automatic test_reset();
    btn = 4'd0;
    rst = 1'b1;
    step(2);
    total++; if (pw.unlock !== 1'b0) $display("FAIL reset_unlock: got %b expected 0", pw.unlock); else passed++;
    total++; if (pw.fail !== 1'b0) $display("FAIL reset_fail: got %b expected 0", pw.fail); else passed++;
    total++; if (pw.locked_out !== 1'b0) $display("FAIL reset_locked: got %b expected 0", pw.locked_out); else passed++;
    total++; if (pw.entry_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", pw.entry_count); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_correct();
    int t_d;
    do_reset(); clear_mon();
    press(4'b0001, 5, 5);
    press(4'b0010, 5, 5);
    total++; if (pw.entry_count !== 3'd2) $display("FAIL correct_count2: got %0d expected 2", pw.entry_count); else passed++;
    press(4'b0100, 5, 5);
    t_d = cyc;
    press(4'b1000, 5, 5);
    step(15);
    total++; if (first_unlock_cyc !== t_d + 3) $display("FAIL correct_unlock_start: got %0d expected %0d", first_unlock_cyc, t_d + 3); else passed++;
    total++; if (n_unlock !== OpenCyc) $display("FAIL correct_unlock_len: got %0d expected %0d", n_unlock, OpenCyc); else passed++;
    total++; if (n_fail !== 0) $display("FAIL correct_no_fail: got %0d expected 0", n_fail); else passed++;
    total++; if (pw.entry_count !== 3'd0) $display("FAIL correct_count_end: got %0d expected 0", pw.entry_count); else passed++;
    total++; if (mon_diff !== 0) $display("FAIL correct_model: %0d cycles differ, first at %0d got %b expected %b", mon_diff, diff_cyc, diff_dut, diff_exp); else passed++;
  endtask

  task automatic test_wrong();
    int t_c;
    do_reset(); clear_mon();
    press(4'b0001, 5, 5);
    press(4'b0010, 5, 5);
    press(4'b1000, 5, 5);
    t_c = cyc;
    press(4'b0100, 5, 5);
    step(15);
    total++; if (n_fail !== 1) $display("FAIL wrong_fail_cnt: got %0d expected 1", n_fail); else passed++;
    total++; if (last_fail_cyc !== t_c + 3) $display("FAIL wrong_fail_time: got %0d expected %0d", last_fail_cyc, t_c + 3); else passed++;
    total++; if (n_unlock !== 0) $display("FAIL wrong_no_unlock: got %0d expected 0", n_unlock); else passed++;
    total++; if (pw.entry_count !== 3'd0) $display("FAIL wrong_count_end: got %0d expected 0", pw.entry_count); else passed++;
    total++; if (mon_diff !== 0) $display("FAIL wrong_model: %0d cycles differ, first at %0d got %b expected %b", mon_diff, diff_cyc, diff_dut, diff_exp); else passed++;
  endtask

  task automatic test_timeout();
    int t_a;
    do_reset(); clear_mon();
    t_a = cyc;
    press(4'b0001, 5, 0);
    step(25);
    total++; if (n_fail !== 1) $display("FAIL timeout_fail_cnt: got %0d expected 1", n_fail); else passed++;
    total++; if (last_fail_cyc !== t_a + 3 + Timeout) $display("FAIL timeout_fail_time: got %0d expected %0d", last_fail_cyc, t_a + 3 + Timeout); else passed++;
    total++; if (pw.entry_count !== 3'd0) $display("FAIL timeout_count_end: got %0d expected 0", pw.entry_count); else passed++;
    total++; if (mon_diff !== 0) $display("FAIL timeout_model: %0d cycles differ, first at %0d got %b expected %b", mon_diff, diff_cyc, diff_dut, diff_exp); else passed++;
  endtask

  task automatic test_lockout();
    do_reset(); clear_mon();
    for (int e = 0; e < MaxFails; e++)
      for (int k = 0; k < 4; k++) press(4'b1000, 2, 2);
    for (int k = 0; k < 4; k++) press(4'b0001 << k, 2, 2);
    step(30);
    total++; if (n_fail !== MaxFails) $display("FAIL lockout_fail_cnt: got %0d expected %0d", n_fail, MaxFails); else passed++;
    total++; if (n_lock !== LockCyc) $display("FAIL lockout_len: got %0d expected %0d", n_lock, LockCyc); else passed++;
    total++; if (n_unlock !== 0) $display("FAIL lockout_ignored: got %0d expected 0", n_unlock); else passed++;
    for (int k = 0; k < 4; k++) press(4'b0001 << k, 3, 3);
    step(15);
    total++; if (n_unlock !== OpenCyc) $display("FAIL lockout_then_unlock: got %0d expected %0d", n_unlock, OpenCyc); else passed++;
    total++; if (n_overlap !== 0) $display("FAIL lockout_overlap: got %0d expected 0", n_overlap); else passed++;
    total++; if (mon_diff !== 0) $display("FAIL lockout_model: %0d cycles differ, first at %0d got %b expected %b", mon_diff, diff_cyc, diff_dut, diff_exp); else passed++;
  endtask

  task automatic test_invalid();
    do_reset(); clear_mon();
    press(4'b0011, 5, 5);
    total++; if (pw.entry_count !== 3'd1) $display("FAIL invalid_chord_count: got %0d expected 1", pw.entry_count); else passed++;
    press(4'b0100, 5, 5);
    press(4'b1000, 5, 5);
    press(4'b0001, 5, 5);
    total++; if (n_fail !== 1) $display("FAIL invalid_chord_fail: got %0d expected 1", n_fail); else passed++;
    btn = 4'b0001; step(4);
    btn = 4'b0011; step(4);
    btn = 4'b0000; step(4);
    press(4'b0100, 4, 4);
    press(4'b1000, 4, 6);
    total++; if (n_fail !== 2) $display("FAIL invalid_held_fail: got %0d expected 2", n_fail); else passed++;
    total++; if (n_unlock !== 0) $display("FAIL invalid_no_unlock: got %0d expected 0", n_unlock); else passed++;
    total++; if (mon_diff !== 0) $display("FAIL invalid_model: %0d cycles differ, first at %0d got %b expected %b", mon_diff, diff_cyc, diff_dut, diff_exp); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset(); clear_mon();
    press(4'b0001, 3, 3);
    press(4'b0010, 3, 3);
    total++; if (pw.entry_count !== 3'd2) $display("FAIL midreset_pre_count: got %0d expected 2", pw.entry_count); else passed++;
    rst = 1'b1; step(1); rst = 1'b0;
    total++; if (pw.entry_count !== 3'd0) $display("FAIL midreset_entry_count: got %0d expected 0", pw.entry_count); else passed++;
    for (int k = 0; k < 4; k++) press(4'b0001 << k, 3, 3);
    total++; if (pw.unlock !== 1'b1) $display("FAIL midreset_open_pre: got %b expected 1", pw.unlock); else passed++;
    rst = 1'b1; step(1); rst = 1'b0;
    total++; if ({pw.unlock, pw.fail, pw.locked_out, pw.entry_count} !== 6'd0) $display("FAIL midreset_open_outputs: got %b expected 000000", {pw.unlock, pw.fail, pw.locked_out, pw.entry_count}); else passed++;
    total++; if (mon_diff !== 0) $display("FAIL midreset_model_a: %0d cycles differ, first at %0d got %b expected %b", mon_diff, diff_cyc, diff_dut, diff_exp); else passed++;
    clear_mon();
    for (int k = 0; k < 4; k++) press(4'b0001 << k, 3, 3);
    step(15);
    total++; if (n_unlock !== OpenCyc) $display("FAIL midreset_fresh_unlock: got %0d expected %0d", n_unlock, OpenCyc); else passed++;
    total++; if (mon_diff !== 0) $display("FAIL midreset_model_b: %0d cycles differ, first at %0d got %b expected %b", mon_diff, diff_cyc, diff_dut, diff_exp); else passed++;
  endtask

  task automatic test_random();
    int r;
    logic [3:0] m1, m2;
    do_reset(); clear_mon();
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        for (int k = 0; k < 4; k++)
          press(4'b0001 << k, $urandom_range(1, 4), $urandom_range(1, 4));
      end else if (r < 7) begin
        press(4'b0001 << $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(1, 4));
      end else if (r == 7) begin
        m1 = 4'(1 << $urandom_range(0, 3));
        m2 = 4'(1 << $urandom_range(0, 3));
        press(m1 | m2 | 4'(1 << $urandom_range(0, 3)), $urandom_range(1, 4), $urandom_range(1, 4));
      end else if (r == 8) begin
        m1 = 4'(1 << $urandom_range(0, 3));
        m2 = 4'(1 << $urandom_range(0, 3));
        btn = m1; step($urandom_range(1, 4));
        btn = m1 | m2; step($urandom_range(1, 4));
        btn = 4'd0; step($urandom_range(1, 4));
      end else begin
        step($urandom_range(18, 24));
      end
    end
    step(50);
    total++; if (n_overlap !== 0) $display("FAIL random_overlap: got %0d expected 0", n_overlap); else passed++;
    total++; if (mon_diff !== 0) $display("FAIL random_model: %0d cycles differ, first at %0d got %b expected %b", mon_diff, diff_cyc, diff_dut, diff_exp); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    btn    = 4'd0;
    clear_mon();
    step(2);
    test_reset();
    test_correct();
    test_wrong();
    test_timeout();
    test_lockout();
    test_invalid();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
